dmem_mmio_ctrl: RTL and testbench
=================================

Name: dmem_mmio_ctrl

Overview:
- Data-memory stage controller for the pipelined CPU. Combines a word-addressed data RAM with byte-lane writes and a memory-mapped IO window.
- The IO window holds a registered LED port, a synchronised switch port, and a 32-bit compare timer with an interrupt flag.
- Sits in the MEM stage. Reads are same-cycle combinational; all writes and state updates occur on the rising clock edge.

Parameters:
- ADDR_W, 14, word-address bits for the RAM; depth is 2**ADDR_W words.
- LED_W, 24, LED output width (1..32).
- SW_W, 24, switch input width (1..32).
- IO_BASE, 32'hFFFF_F000, base of the 4 KB IO window, matched on addr[31:12].

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  reset.
- addr  in  32  byte address from the ALU; addr[1:0] ignored.
- we  in  1  store strobe.
- be  in  4  byte enables; be[i] gates wdata[8i+7:8i].
- wdata  in  32  store data.
- rdata  out  32  load data, combinational from addr.
- sw_in  in  SW_W  raw switch pins, asynchronous.
- led_out  out  LED_W  LED register.
- timer_irq  out  1  level interrupt equal to the status flag.

Behaviour:
- Reset: rst_n, synchronous, active-low. While low, on each posedge:
  - led_out=0, timer count=0, compare=32'hFFFF_FFFF, ctrl=0, irq flag=0 (timer_irq=0).
  - Both switch sync stages are cleared to 0.
  - RAM contents are not reset.
  - Writes presented during reset are dropped.
- Decode:
  - io_sel = (addr[31:12]==IO_BASE[31:12]); otherwise RAM.
  - RAM index = addr[ADDR_W+1:2]; higher bits are ignored, so the address wraps modulo the depth.
- RAM write: on posedge, when we && !io_sel, each byte lane with be[i]=1 is written; other lanes are kept. be=0 is a no-op.
- RAM read: rdata = mem[index] in the same cycle. A read of the address being written in that cycle returns the old word; the new word is visible the next cycle.
- IO map (offset = addr[11:0], word aligned):
  - 0x060 LED, RW:
    - Write updates the enabled bytes of the LED register; bits >= LED_W are discarded.
    - Read returns the register zero-extended.
    - An IO write never touches RAM.
  - 0x070 SW, RO:
    - Read returns sw_sync2 zero-extended.
    - sw_in passes through two flops, so latency from a pin change to read-visibility is 2 posedges.
    - Writes are ignored.
  - 0x080 COUNT, RW: 32-bit counter.
  - 0x084 COMPARE, RW: 32 bits.
  - 0x088 CTRL, RW:
    - bit0 enable, bit1 auto-reload. Other bits read 0.
  - 0x08C STATUS: bit0 irq flag.
    - Write with wdata[0]=1 and be[0]=1 clears the flag (W1C).
  - Unmapped offsets read 0; writes are ignored.
- Timer, per posedge when enable=1:
  - If count==compare: set the irq flag, then count <= 0 if auto-reload is set, else count+1 (wraps 32'hFFFF_FFFF -> 0).
  - Otherwise count <= count+1.
  - When enable=0, count holds.
- Simultaneous events:
  - A CPU write to COUNT overrides the increment/reload in that cycle.
  - A match that sets the flag beats a W1C clear in the same cycle; the flag stays 1.
  - A write to CTRL takes effect from the next cycle.
  - A partial byte-enable write to COUNT/COMPARE/CTRL updates only the enabled bytes.
- timer_irq is driven directly from the flag register: no combinational path from inputs, zero added latency.

Test Plan:
- RAM byte lanes:
  - Write 0x11223344 be=1111 at 0x100, then 0xAA be=0010 at 0x100 -> read 0x1122AA44.
  - Write at 0x100+4*2**ADDR_W -> aliases to index 0x40.
- LED and SW:
  - Write 0xDEADBEEF be=1111 to IO_BASE+0x060 -> led_out=0xADBEEF, RAM unchanged.
  - sw_in=0x00A5A5 -> read of 0x070 returns 0x000000A5A5 zero-extended two cycles later, 0 before that.
- Timer auto-reload:
  - COMPARE=3, CTRL=3 -> count sequence 0,1,2,3,0,1.
  - timer_irq rises the cycle after count==3 is first seen and stays high.
  - W1C to STATUS drops it; a clear coinciding with the next match keeps it 1.
- Timer free-run wrap: COUNT=32'hFFFF_FFFE, COMPARE=5, CTRL=1 -> count goes FFFF_FFFF, 0, ... 5; irq flag sets at the match.
- Reset mid-operation:
  - Assert rst_n=0 for one edge with timer running and LED=0x123 -> all outputs and registers at reset values; RAM data retained.
  - A simultaneous store is dropped.
- Unmapped and read-during-write:
  - Read IO_BASE+0x0F0 -> 0.
  - Store and load the same RAM word in one cycle -> old value returned; new value on the next cycle.

Source files
------------

// File: rtl/dmem_mmio_ctrl.sv
// MEM-stage data controller: word-addressed RAM with byte-lane stores, plus an IO
// window holding an LED register, a synchronised switch port and a compare timer.
module dmem_mmio_ctrl #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned LED_W   = 24,
  parameter int unsigned SW_W    = 24,
  parameter logic [31:0] IO_BASE = 32'hFFFF_F000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic              timer_irq
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // IO register offsets expressed as word offsets (addr[11:2]).
  localparam logic [9:0] OFF_LED     = 10'h018;
  localparam logic [9:0] OFF_SW      = 10'h01C;
  localparam logic [9:0] OFF_COUNT   = 10'h020;
  localparam logic [9:0] OFF_COMPARE = 10'h021;
  localparam logic [9:0] OFF_CTRL    = 10'h022;
  localparam logic [9:0] OFF_STATUS  = 10'h023;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0]       mem_r [DEPTH];
  logic [LED_W-1:0]  led_r;
  logic [SW_W-1:0]   sw_sync1_r;
  logic [SW_W-1:0]   sw_sync2_r;
  logic [31:0]       count_r;
  logic [31:0]       compare_r;
  logic [1:0]        ctrl_r;
  logic              irq_r;

  logic              io_sel_s;
  logic [ADDR_W-1:0] index_s;
  logic [9:0]        word_off_s;
  logic              io_wr_s;
  logic              ram_wr_s;
  logic              match_s;
  logic              w1c_s;
  logic [31:0]       led_ext_s;
  logic [31:0]       sw_ext_s;
  logic [31:0]       led_wr_s;
  logic [31:0]       ctrl_wr_s;
  logic [31:0]       count_step_s;
  logic [31:0]       count_nxt_s;
  logic              irq_nxt_s;
  logic              unused_s;

  assign io_sel_s   = (addr[31:12] == IO_BASE[31:12]);
  assign index_s    = addr[ADDR_W+1:2];
  assign word_off_s = addr[11:2];
  assign io_wr_s    = we & io_sel_s;
  assign ram_wr_s   = we & ~io_sel_s;
  assign match_s    = (count_r == compare_r);
  assign w1c_s      = io_wr_s & (word_off_s == OFF_STATUS) & be[0] & wdata[0];
  assign led_wr_s   = lane_merge(led_ext_s, wdata, be);
  assign ctrl_wr_s  = lane_merge({30'd0, ctrl_r}, wdata, be);
  assign unused_s   = ^{addr[1:0], led_wr_s, ctrl_wr_s};

  assign led_out    = led_r;
  assign timer_irq  = irq_r;

  // Zero-extend the narrow IO registers to bus width.
  always_comb begin
    led_ext_s = 32'd0;
    sw_ext_s  = 32'd0;
    led_ext_s[LED_W-1:0] = led_r;
    sw_ext_s[SW_W-1:0]   = sw_sync2_r;
  end

  // Timer next state: a set from a match wins over a W1C, a CPU COUNT write wins over counting.
  always_comb begin
    count_step_s = count_r;
    irq_nxt_s    = w1c_s ? 1'b0 : irq_r;
    if (ctrl_r[0]) begin
      if (match_s) begin
        irq_nxt_s    = 1'b1;
        count_step_s = ctrl_r[1] ? 32'd0 : count_r + 32'd1;
      end else begin
        count_step_s = count_r + 32'd1;
      end
    end else begin
      count_step_s = count_r;
    end
    if (io_wr_s && (word_off_s == OFF_COUNT)) begin
      count_nxt_s = lane_merge(count_r, wdata, be);
    end else begin
      count_nxt_s = count_step_s;
    end
  end

  // IO registers, switch synchroniser and timer state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_r      <= {LED_W{1'b0}};
      sw_sync1_r <= {SW_W{1'b0}};
      sw_sync2_r <= {SW_W{1'b0}};
      count_r    <= 32'd0;
      compare_r  <= 32'hFFFF_FFFF;
      ctrl_r     <= 2'd0;
      irq_r      <= 1'b0;
    end else begin
      sw_sync1_r <= sw_in;
      sw_sync2_r <= sw_sync1_r;
      count_r    <= count_nxt_s;
      irq_r      <= irq_nxt_s;
      if (io_wr_s) begin
        case (word_off_s)
          OFF_LED:     led_r     <= led_wr_s[LED_W-1:0];
          OFF_COMPARE: compare_r <= lane_merge(compare_r, wdata, be);
          OFF_CTRL:    ctrl_r    <= ctrl_wr_s[1:0];
          default:     ;
        endcase
      end
    end
  end

  // RAM byte-lane store; contents survive reset but stores during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst_n && ram_wr_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_r[index_s][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Combinational load path; a same-cycle store is only visible after the edge.
  always_comb begin
    rdata = 32'd0;
    if (io_sel_s) begin
      case (word_off_s)
        OFF_LED:     rdata = led_ext_s;
        OFF_SW:      rdata = sw_ext_s;
        OFF_COUNT:   rdata = count_r;
        OFF_COMPARE: rdata = compare_r;
        OFF_CTRL:    rdata = {30'd0, ctrl_r};
        OFF_STATUS:  rdata = {31'd0, irq_r};
        default:     rdata = 32'd0;
      endcase
    end else begin
      rdata = mem_r[index_s];
    end
  end

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// Scoreboard bench for dmem_mmio_ctrl: directed test-plan sequences then random
// traffic, all checked against a behavioural model of the memory map and timer.
module tb_dmem_mmio_ctrl;

  localparam int ADDR_W = 14;
  localparam int LED_W  = 24;
  localparam int SW_W   = 24;
  localparam logic [31:0] IO = 32'hFFFF_F000;
  localparam int DEPTH = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       addr;
  logic              we;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [SW_W-1:0]   sw_in;
  logic [LED_W-1:0]  led_out;
  logic              timer_irq;

  dmem_mmio_ctrl #(.ADDR_W(ADDR_W), .LED_W(LED_W), .SW_W(SW_W), .IO_BASE(IO)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .be(be), .wdata(wdata),
    .rdata(rdata), .sw_in(sw_in), .led_out(led_out), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    bit               chk_rd;
    logic [31:0]      rd;
    logic [LED_W-1:0] led;
    logic             irq;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Behavioural model of the architectural state.
  logic [31:0]      ram_m [int];
  logic [LED_W-1:0] led_m  = '0;
  logic [SW_W-1:0]  sw1_m  = '0;
  logic [SW_W-1:0]  sw2_m  = '0;
  logic [31:0]      cnt_m  = 32'd0;
  logic [31:0]      cmp_m  = 32'hFFFF_FFFF;
  logic             en_m   = 1'b0;
  logic             ar_m   = 1'b0;
  logic             flag_m = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic int ram_idx(input logic [31:0] a);
    return int'((a >> 2) % 32'(DEPTH));
  endfunction

  function automatic void model_read(input logic [31:0] a, output bit chk, output logic [31:0] rd);
    chk = 1'b1;
    rd  = 32'd0;
    if (a[31:12] == IO[31:12]) begin
      case ({a[11:2], 2'b00})
        12'h060: rd = 32'(led_m);
        12'h070: rd = 32'(sw2_m);
        12'h080: rd = cnt_m;
        12'h084: rd = cmp_m;
        12'h088: rd = {30'd0, ar_m, en_m};
        12'h08C: rd = {31'd0, flag_m};
        default: rd = 32'd0;
      endcase
    end else if (ram_m.exists(ram_idx(a))) begin
      rd = ram_m[ram_idx(a)];
    end else begin
      chk = 1'b0;
    end
  endfunction

  function automatic void model_step(input logic rn, input logic [31:0] a, input logic w,
                                     input logic [3:0] b, input logic [31:0] d,
                                     input logic [SW_W-1:0] s);
    logic [31:0] nc, t;
    logic        nf, io;
    logic [11:0] off;
    int          idx;
    if (!rn) begin
      led_m = '0; sw1_m = '0; sw2_m = '0; cnt_m = 32'd0; cmp_m = 32'hFFFF_FFFF;
      en_m = 1'b0; ar_m = 1'b0; flag_m = 1'b0;
      return;
    end
    io  = (a[31:12] == IO[31:12]);
    off = {a[11:2], 2'b00};
    sw2_m = sw1_m;
    sw1_m = s;
    nc = cnt_m;
    nf = flag_m;
    if (w && io && off == 12'h08C && b[0] && d[0]) nf = 1'b0;
    if (en_m) begin
      if (cnt_m == cmp_m) begin
        nf = 1'b1;
        nc = ar_m ? 32'd0 : cnt_m + 32'd1;
      end else begin
        nc = cnt_m + 32'd1;
      end
    end
    if (w && io) begin
      case (off)
        12'h060: begin t = merge(32'(led_m), d, b); led_m = t[LED_W-1:0]; end
        12'h080: nc = merge(cnt_m, d, b);
        12'h084: cmp_m = merge(cmp_m, d, b);
        12'h088: begin t = merge({30'd0, ar_m, en_m}, d, b); en_m = t[0]; ar_m = t[1]; end
        default: ;
      endcase
    end else if (w) begin
      idx = ram_idx(a);
      if (ram_m.exists(idx)) ram_m[idx] = merge(ram_m[idx], d, b);
      else if (b == 4'hF) ram_m[idx] = d;
    end
    cnt_m  = nc;
    flag_m = nf;
  endfunction

  // Drive one cycle, push the expected response, advance the model across the edge.
  task automatic cyc(input string tag, input logic rn, input logic [31:0] a, input logic w,
                     input logic [3:0] b, input logic [31:0] d,
                     input bit fix = 1'b0, input logic [31:0] fixv = 32'd0);
    exp_t e;
    rst_n = rn; addr = a; we = w; be = b; wdata = d;
    e.tag = tag;
    e.led = led_m;
    e.irq = flag_m;
    model_read(a, e.chk_rd, e.rd);
    if (fix) begin
      e.chk_rd = 1'b1;
      e.rd     = fixv;
    end
    sb.push_back(e);
    model_step(rn, a, w, b, d, sw_in);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented cycle against the oldest scoreboard entry.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      vectors++;
      if (led_out !== mon_e.led) begin
        miscompares++;
        $display("FAIL %s led_out: got %h want %h", mon_e.tag, led_out, mon_e.led);
      end
      vectors++;
      if (timer_irq !== mon_e.irq) begin
        miscompares++;
        $display("FAIL %s timer_irq: got %b want %b", mon_e.tag, timer_irq, mon_e.irq);
      end
      if (mon_e.chk_rd) begin
        vectors++;
        if (rdata !== mon_e.rd) begin
          miscompares++;
          $display("FAIL %s rdata: got %h want %h (addr %h)", mon_e.tag, rdata, mon_e.rd, addr);
        end
      end
    end
  end

  logic [11:0] offs [8] = '{12'h060, 12'h070, 12'h080, 12'h084, 12'h088, 12'h08C, 12'h0F0, 12'h000};

  initial begin
    logic [31:0] a, d;
    logic        w, rn;
    logic [3:0]  b;
    logic [11:0] off;
    rst_n = 1'b0; addr = 32'd0; we = 1'b0; be = 4'd0; wdata = 32'd0; sw_in = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    cyc("rst_compare", 1'b1, IO | 32'h084, 1'b0, 4'h0, 32'd0, 1'b1, 32'hFFFF_FFFF);
    cyc("rst_count",   1'b1, IO | 32'h080, 1'b0, 4'h0, 32'd0, 1'b1, 32'd0);
    cyc("rst_ctrl",    1'b1, IO | 32'h088, 1'b0, 4'h0, 32'd0, 1'b1, 32'd0);

    // RAM byte lanes and aliasing
    cyc("ram_full",  1'b1, 32'h100, 1'b1, 4'hF, 32'h1122_3344);
    cyc("ram_lane1", 1'b1, 32'h100, 1'b1, 4'h2, 32'h0000_AA00);
    cyc("ram_merge", 1'b1, 32'h100, 1'b0, 4'h0, 32'd0, 1'b1, 32'h1122_AA44);
    cyc("ram_alias_wr", 1'b1, 32'h100 + 32'(4 * DEPTH), 1'b1, 4'hF, 32'h5555_AAAA);
    cyc("ram_alias_rd", 1'b1, 32'h100, 1'b0, 4'h0, 32'd0, 1'b1, 32'h5555_AAAA);
    cyc("ram_be0", 1'b1, 32'h100, 1'b1, 4'h0, 32'hFFFF_FFFF);
    cyc("ram_be0_rd", 1'b1, 32'h100, 1'b0, 4'h0, 32'd0, 1'b1, 32'h5555_AAAA);

    // Read during write
    cyc("rdw_old", 1'b1, 32'h100, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b1, 32'h5555_AAAA);
    cyc("rdw_new", 1'b1, 32'h100, 1'b0, 4'h0, 32'd0, 1'b1, 32'hCAFE_F00D);

    // LED write must not touch the RAM word sharing its index
    cyc("led_shadow_init", 1'b1, 32'h0000_F060, 1'b1, 4'hF, 32'h0BAD_CAFE);
    cyc("led_wr", 1'b1, IO | 32'h060, 1'b1, 4'hF, 32'hDEAD_BEEF);
    cyc("led_rd", 1'b1, IO | 32'h060, 1'b0, 4'h0, 32'd0, 1'b1, 32'h00AD_BEEF);
    cyc("led_ram_kept", 1'b1, 32'h0000_F060, 1'b0, 4'h0, 32'd0, 1'b1, 32'h0BAD_CAFE);

    // Switch synchroniser latency
    sw_in = 24'h00A5A5;
    cyc("sw_lat0", 1'b1, IO | 32'h070, 1'b0, 4'h0, 32'd0, 1'b1, 32'd0);
    cyc("sw_lat1", 1'b1, IO | 32'h070, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'd0);
    cyc("sw_lat2", 1'b1, IO | 32'h070, 1'b0, 4'h0, 32'd0, 1'b1, 32'h0000_A5A5);

    // Unmapped
    cyc("unmapped_wr", 1'b1, IO | 32'h0F0, 1'b1, 4'hF, 32'h1234_5678, 1'b1, 32'd0);
    cyc("unmapped_rd", 1'b1, IO | 32'h0F0, 1'b0, 4'h0, 32'd0, 1'b1, 32'd0);

    // Auto-reload timer: count 0,1,2,3,0,1 with W1C interplay
    cyc("ar_cmp",  1'b1, IO | 32'h084, 1'b1, 4'hF, 32'd3, 1'b1, 32'hFFFF_FFFF);
    cyc("ar_ctrl", 1'b1, IO | 32'h088, 1'b1, 4'hF, 32'd3, 1'b1, 32'd0);
    for (int i = 0; i < 6; i++)
      cyc("ar_seq", 1'b1, IO | 32'h080, 1'b0, 4'h0, 32'd0, 1'b1, 32'(i % 4));
    cyc("w1c_drop",  1'b1, IO | 32'h08C, 1'b1, 4'h1, 32'd1, 1'b1, 32'd1);
    cyc("w1c_vs_match", 1'b1, IO | 32'h08C, 1'b1, 4'h1, 32'd1, 1'b1, 32'd0);
    cyc("match_wins", 1'b1, IO | 32'h08C, 1'b0, 4'h0, 32'd0, 1'b1, 32'd1);
    cyc("ar_after", 1'b1, IO | 32'h080, 1'b0, 4'h0, 32'd0, 1'b1, 32'd1);

    // Free-running wrap
    cyc("fr_stop",  1'b1, IO | 32'h088, 1'b1, 4'hF, 32'd0, 1'b1, 32'd3);
    cyc("fr_count", 1'b1, IO | 32'h080, 1'b1, 4'hF, 32'hFFFF_FFFE);
    cyc("fr_cmp",   1'b1, IO | 32'h084, 1'b1, 4'hF, 32'd5, 1'b1, 32'd3);
    cyc("fr_clr",   1'b1, IO | 32'h08C, 1'b1, 4'hF, 32'd1, 1'b1, 32'd1);
    cyc("fr_start", 1'b1, IO | 32'h088, 1'b1, 4'hF, 32'd1, 1'b1, 32'd0);
    for (int i = 0; i < 8; i++)
      cyc("fr_seq", 1'b1, IO | 32'h080, 1'b0, 4'h0, 32'd0, 1'b1, 32'hFFFF_FFFE + 32'(i));
    cyc("fr_flag",  1'b1, IO | 32'h08C, 1'b0, 4'h0, 32'd0, 1'b1, 32'd1);
    cyc("fr_norel", 1'b1, IO | 32'h080, 1'b0, 4'h0, 32'd0, 1'b1, 32'd7);

    // Reset mid-operation with a store in the reset cycle
    cyc("mr_led", 1'b1, IO | 32'h060, 1'b1, 4'hF, 32'h0000_0123);
    cyc("mr_ram", 1'b1, 32'h200, 1'b1, 4'hF, 32'h600D_D00D);
    cyc("mr_rst", 1'b0, 32'h200, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h600D_D00D);
    cyc("mr_count", 1'b1, IO | 32'h080, 1'b0, 4'h0, 32'd0, 1'b1, 32'd0);
    cyc("mr_cmp",   1'b1, IO | 32'h084, 1'b0, 4'h0, 32'd0, 1'b1, 32'hFFFF_FFFF);
    cyc("mr_ctrl",  1'b1, IO | 32'h088, 1'b0, 4'h0, 32'd0, 1'b1, 32'd0);
    cyc("mr_ledrd", 1'b1, IO | 32'h060, 1'b0, 4'h0, 32'd0, 1'b1, 32'd0);
    cyc("mr_kept",  1'b1, 32'h200, 1'b0, 4'h0, 32'd0, 1'b1, 32'h600D_D00D);

    // Random traffic over 16 RAM words and the IO map
    for (int i = 0; i < 16; i++)
      cyc("rnd_init", 1'b1, 32'(i * 4), 1'b1, 4'hF, $urandom);
    for (int i = 0; i < 400; i++) begin
      rn = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      w  = 1'($urandom_range(0, 1));
      b  = 4'($urandom_range(0, 15));
      d  = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        a = {1'b0, 15'($urandom), 10'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      end else begin
        off = offs[$urandom_range(0, 7)];
        a = IO | 32'(off) | 32'($urandom_range(0, 3));
        if (off == 12'h080 || off == 12'h084) d = 32'($urandom_range(0, 40));
      end
      if ($urandom_range(0, 3) == 0) sw_in = SW_W'($urandom);
      cyc("rnd", rn, a, w, b, d);
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
